// File: rtl/pipe_drawer_if.sv
// Pipe drawer signal bundle: coordinate/tick inputs and the VGA adapter write port.
// The drawer uses the slave modport, whoever drives coordinates uses master.
interface pipe_drawer_if;
   logic       game_clk;
   logic [7:0] pipe_x;
   logic [6:0] gap_y;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output game_clk, pipe_x, gap_y,
      input  vga_x, vga_y, colour, plot, busy, done
   );

   modport slave (
      input  game_clk, pipe_x, gap_y,
      output vga_x, vga_y, colour, plot, busy, done
   );
endinterface

// File: rtl/pipe_drawer.sv
// Repaints one pipe (body, gap, trailing erase column) into the VGA adapter on
// every game tick, one pixel per clock, column-major.
//
// state | meaning
// IDLE  | waiting for a game tick
// LOAD  | latch pipe_x/gap_y, clear counters
// DRAW  | present pixel (c_q, r_q)
// DONE  | one-cycle completion pulse; relaunch if a tick is pending
module pipe_drawer #(
   parameter int          PIPE_W      = 8,
   parameter int          GAP_H       = 20,
   parameter int          SCREEN_W    = 160,
   parameter int          SCREEN_H    = 120,
   parameter logic [2:0]  PIPE_COLOUR = 3'b010,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   pipe_drawer_if.slave  bus
);
   localparam int CW = $clog2(PIPE_W + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DRAW = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic          meta_q, sync_q, prev_q;
   logic          tick;
   logic [1:0]    state_q, state_d;
   logic [7:0]    px_q, px_d;
   logic [6:0]    gy_q, gy_d;
   logic [CW-1:0] c_q, c_d;
   logic [6:0]    r_q, r_d;
   logic          pending_q, pending_d;
   logic [7:0]    vga_x_q, vga_x_d;
   logic [6:0]    vga_y_q, vga_y_d;
   logic [2:0]    colour_q, colour_d;
   logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;
   logic [7:0]    col_d, row8_d, gy8_d;
   logic          in_gap_d, erase_d;

   // Synchroniser runs through reset so it is settled when reset releases.
   always_ff @(posedge CLOCK_50) begin
      meta_q <= bus.game_clk;
      sync_q <= meta_q;
      prev_q <= sync_q;
   end

   assign tick = sync_q & ~prev_q;

   always_comb begin
      state_d   = state_q;
      px_d      = px_q;
      gy_d      = gy_q;
      c_d       = c_q;
      r_d       = r_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: if (tick) state_d = LOAD;
         LOAD: begin
            px_d    = bus.pipe_x;
            gy_d    = bus.gap_y;
            c_d     = '0;
            r_d     = '0;
            state_d = DRAW;
            if (tick) pending_d = 1'b1;
         end
         DRAW: begin
            if (tick) pending_d = 1'b1;
            if (r_q == 7'(SCREEN_H - 1)) begin
               r_d = '0;
               if (c_q == CW'(PIPE_W)) state_d = DONE;
               else                    c_d = c_q + 1'b1;
            end else begin
               r_d = r_q + 1'b1;
            end
         end
         default: begin
            // A tick landing in DONE itself must not be lost on the way to IDLE.
            if (pending_q || tick) begin
               pending_d = 1'b0;
               state_d   = LOAD;
            end else begin
               state_d   = IDLE;
            end
         end
      endcase
   end

   // Output registers are loaded with the pixel that the next DRAW cycle presents.
   always_comb begin
      col_d    = px_d + 8'(c_d);
      row8_d   = {1'b0, r_d};
      gy8_d    = {1'b0, gy_d};
      in_gap_d = (row8_d >= gy8_d) && (row8_d < gy8_d + 8'(GAP_H));
      erase_d  = (c_d == CW'(PIPE_W));
      vga_x_d  = '0;
      vga_y_d  = '0;
      colour_d = '0;
      plot_d   = 1'b0;
      if (state_d == DRAW) begin
         vga_x_d  = col_d;
         vga_y_d  = r_d;
         colour_d = (erase_d || in_gap_d) ? BG_COLOUR : PIPE_COLOUR;
         plot_d   = (col_d < 8'(SCREEN_W));
      end
      busy_d = (state_d == LOAD) || (state_d == DRAW);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         px_q      <= '0;
         gy_q      <= '0;
         c_q       <= '0;
         r_q       <= '0;
         pending_q <= 1'b0;
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         colour_q  <= '0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         px_q      <= px_d;
         gy_q      <= gy_d;
         c_q       <= c_d;
         r_q       <= r_d;
         pending_q <= pending_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.vga_x  = vga_x_q;
   assign bus.vga_y  = vga_y_q;
   assign bus.colour = colour_q;
   assign bus.plot   = plot_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule
